// File: rtl/rv32_types.sv
// Shared types for the rv32 memory arbiter: request fields, FSM states and owner tags.
package rv32_types;

    // Starvation counter width; STARVE_LIMIT must fit (1..15).
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic {
        ARB_OWN_I,
        ARB_OWN_D
    } arb_owner_t;

endpackage

// File: rtl/rv32_arb_pick.sv
// Stateless winner selection: D wins unless I has been starved for STARVE_LIMIT D grants.
module rv32_arb_pick
    import rv32_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output arb_owner_t       winner
);

    logic i_starved;

    assign i_starved = i_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Default to I so an idle cycle presents the fetch fields on the memory port.
    always_comb begin
        winner = ARB_OWN_I;
        if (d_req && !i_starved) begin
            winner = ARB_OWN_D;
        end
    end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto one memory port, one transaction in flight.
// Optional macro RV32_ARB_PERF_EN adds grant and conflict-cycle performance counters.
module rv32_mem_arbiter
    import rv32_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              resetn,
    // Fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_kill,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    // Data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    // Memory port
    output logic              m_req,
    output logic              m_we,
    output logic [3:0]        m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
`ifdef RV32_ARB_PERF_EN
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflict_cycles,
`endif
    input  logic [31:0]       m_rdata
);

    arb_state_t       state_q;
    arb_owner_t       owner_q;
    logic             drop_q;
    logic [CNT_W-1:0] cnt_q;

    arb_owner_t pick_owner;
    arb_owner_t cur_owner;
    mem_req_t   i_fields;
    mem_req_t   d_fields;
    mem_req_t   sel;
    logic       grant;
    logic       rsp;

    rv32_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .i_req     (i_req),
        .d_req     (d_req),
        .starve_cnt(cnt_q),
        .winner    (pick_owner)
    );

    // Owner of the memory port this cycle: live pick in IDLE, latched owner afterwards.
    assign cur_owner = (state_q == ARB_IDLE) ? pick_owner : owner_q;

    // Build both candidate requests and mux the owner's onto the memory port.
    always_comb begin
        i_fields = '{we: 1'b0, be: 4'hF, addr: 32'(i_addr), wdata: 32'h0};
        d_fields = '{we: d_we, be: d_be, addr: 32'(d_addr), wdata: d_wdata};
        sel      = (cur_owner == ARB_OWN_D) ? d_fields : i_fields;
    end

    assign m_we    = sel.we;
    assign m_be    = sel.be;
    assign m_addr  = sel.addr[ADDR_W-1:0];
    assign m_wdata = sel.wdata;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    // Request, grant and response strobes; all forced low while reset is held.
    always_comb begin
        m_req    = 1'b0;
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        if (resetn) begin
            case (state_q)
                ARB_IDLE: m_req = i_req | d_req;
                ARB_REQ:  m_req = 1'b1;
                default:  m_req = 1'b0;
            endcase
        end
        grant = m_req & m_gnt;
        i_gnt = grant & (cur_owner == ARB_OWN_I);
        d_gnt = grant & (cur_owner == ARB_OWN_D);
        // Responses are only honoured while waiting; stray m_rvalid elsewhere is dropped.
        rsp      = resetn & (state_q == ARB_WAIT) & m_rvalid;
        // A kill coinciding with the response also discards it.
        i_rvalid = rsp & (owner_q == ARB_OWN_I) & ~drop_q & ~i_kill;
        d_rvalid = rsp & (owner_q == ARB_OWN_D);
    end

    // Transaction sequencing, kill bookkeeping and starvation counting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_OWN_I;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (m_req) begin
                        owner_q <= cur_owner;
                        state_q <= m_gnt ? ARB_WAIT : ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (m_gnt) begin
                        state_q <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (m_rvalid) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase

            if (state_q == ARB_WAIT && m_rvalid) begin
                drop_q <= 1'b0;
            end else if (i_kill && (i_gnt || (state_q != ARB_IDLE && owner_q == ARB_OWN_I))) begin
                drop_q <= 1'b1;
            end

            if (i_gnt) begin
                cnt_q <= '0;
            end else if (d_gnt && i_req && cnt_q < CNT_W'(STARVE_LIMIT)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef RV32_ARB_PERF_EN
    // Free-running wrapping performance counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_i_grants        <= '0;
            perf_d_grants        <= '0;
            perf_conflict_cycles <= '0;
        end else begin
            if (i_gnt) begin
                perf_i_grants <= perf_i_grants + 32'd1;
            end
            if (d_gnt) begin
                perf_d_grants <= perf_d_grants + 32'd1;
            end
            if (state_q == ARB_IDLE && i_req && d_req) begin
                perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Shares one unified memory port between two requesters: instruction fetch (I port) and the data/memory stage (D port).
- Sits between the core's fetch/mem stages and the single external memory.
- Sequences one outstanding transaction at a time and routes each response back to its owner.
- D has priority; a starvation counter guarantees I forward progress. A kill input discards stale fetch responses after a jump.

Parameters:
- STARVE_LIMIT, 4: consecutive D grants allowed while i_req is pending before I is forced to win (range 1..15).
- ADDR_W, 32: address width.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held with i_addr stable until i_gnt
i_addr  in  ADDR_W  fetch address (word aligned)
i_kill  in  1  fetch redirect; drop the pending/outstanding I response
i_gnt  out  1  I request accepted this cycle
i_rvalid  out  1  I read data valid
i_rdata  out  32  I read data
d_req  in  1  data request; fields held stable until d_gnt
d_we  in  1  write enable
d_be  in  4  byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  32  write data
d_gnt  out  1  D request accepted
d_rvalid  out  1  D response (read data or write ack)
d_rdata  out  32  D read data
m_req  out  1  memory request
m_we  out  1  memory write enable (0 for I)
m_be  out  4  byte enables (4'hF for I)
m_addr  out  ADDR_W  memory address
m_wdata  out  32  write data (0 for I)
m_gnt  in  1  memory accepted request
m_rvalid  in  1  memory response, at least 1 cycle after m_gnt
m_rdata  in  32  memory response data

Behaviour:
- Registered state: IDLE, REQ, WAIT. Also owner (I/D), drop flag, and starve counter (4 bits).
- Reset: state=IDLE, owner=I, drop=0, counter=0. While resetn=0: m_req, i_gnt, d_gnt, i_rvalid, d_rvalid are 0. i_rdata and d_rdata are pass-throughs of m_rdata and are meaningful only with rvalid.
- IDLE: winner is picked combinationally.
  - D wins if d_req=1, unless counter==STARVE_LIMIT and i_req=1; then I wins.
  - m_* is driven from the winner and m_req = i_req|d_req.
  - If m_gnt=1: winner's gnt=1, next state WAIT. Else: owner latched, next state REQ.
- REQ: m_* is driven from the latched owner only, so it is stable until accepted. On m_gnt: owner gnt=1, next state WAIT.
- WAIT: m_req=0. On m_rvalid: the owner's rvalid is asserted for 1 cycle (I suppressed if drop=1), drop cleared, next state IDLE.
- Throughput: at most one transaction per 2 cycles. Minimum latency is req→gnt 0 cycles and gnt→rvalid ≥1 cycle.
- Starve counter:
  - On a D grant while i_req=1: increment, saturating at STARVE_LIMIT.
  - On an I grant: cleared to 0.
  - On a D grant with i_req=0: unchanged.
- i_kill:
  - Sets drop when owner=I in REQ or WAIT, or when the I grant happens the same cycle.
  - A REQ-state I request is not withdrawn. The memory response is consumed silently.
  - i_kill in IDLE with no I grant has no effect.
- m_rvalid in IDLE or REQ is a protocol violation: ignored, and no rvalid is forwarded.
- Asynchronous reset mid-transaction abandons it. A late m_rvalid that arrives in IDLE is ignored.
- A requester that deasserts req before gnt is a violation. In REQ, the latched owner's current fields are still forwarded.

Optional Feature:
- Macro RV32_ARB_PERF_EN.
- When defined, adds three output ports, each a 32-bit wrapping counter reset to 0:
  - perf_i_grants
  - perf_d_grants
  - perf_conflict_cycles: cycles in IDLE with i_req&d_req.
- When not defined, the ports and counters are absent and the block is otherwise identical.

Decomposition:
- The shared rv32_types package gets:
  - mem_req_t struct (we, be, addr, wdata)
  - arb_state_t enum (ARB_IDLE, ARB_REQ, ARB_WAIT)
  - arb_owner_t enum (ARB_OWN_I, ARB_OWN_D)
- Sub-module rv32_arb_pick: the combinational winner selection from i_req, d_req, counter, STARVE_LIMIT. It contains no state.

Test Plan:
1. Only i_req, addr 0x100, m_gnt=1 immediately, m_rvalid 2 cycles later with data 0xDEADBEEF → i_gnt in cycle 0, i_rvalid=1 with i_rdata=0xDEADBEEF in cycle 2, d_rvalid stays 0.
2. i_req and d_req both held (D write be=4'h3, addr 0x2000), m_gnt=1 always, rvalid next cycle → D granted first.
   - With STARVE_LIMIT=4 and d_req held: grants follow D,D,D,D,I,D…
3. m_gnt held low 3 cycles with I in REQ; d_req rises in cycle 1 → m_addr stays i_addr for all cycles. I is granted; D is granted only in the next IDLE.
4. I granted, i_kill pulsed in WAIT, m_rvalid arrives → i_rvalid stays 0 and the state returns to IDLE. The next I request completes normally.
5. resetn driven low during WAIT, released, then m_rvalid=1 → no rvalid out and state is IDLE. A new d_req is granted on the first clock after reset release.
6. RV32_ARB_PERF_EN defined, run scenario 2 for 10 transactions → perf_i_grants=2, perf_d_grants=8, perf_conflict_cycles=10.
